// File: rtl/fc_host_pkg.sv
// -----------------------------------------------------------------------------
// fc_host_pkg
// Shared types and helpers for the fc_stream_host block.
//   fc_host_state_t   : run state of the host FSM (IDLE, SEND, RECV, DONE)
//   index_width()     : address width for a buffer of a given depth (min 1 bit)
//   vec_index_width() : width of the vector buffer index, $clog2(N)
//   res_index_width() : width of the result buffer index, $clog2(M)
// -----------------------------------------------------------------------------
package fc_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RECV = 2'd2,
        ST_DONE = 2'd3
    } fc_host_state_t;

    // A depth-1 buffer still needs a one-bit index port.
    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned vec_index_width(input int unsigned n);
        return index_width(n);
    endfunction

    function automatic int unsigned res_index_width(input int unsigned m);
        return index_width(m);
    endfunction

endpackage

// File: rtl/fc_stream_host_if.sv
// -----------------------------------------------------------------------------
// fc_stream_host_if
// The two valid/ready channels between the host and an fc_* layer.
//   tx_* : host -> layer input stream  (tx_valid, tx_data from host; tx_ready back)
//   rx_* : layer -> host output stream (rx_valid, rx_data from layer; rx_ready back)
// Modports:
//   master : the host side (drives tx_valid/tx_data and rx_ready)
//   slave  : the layer side (drives tx_ready, rx_valid and rx_data)
// -----------------------------------------------------------------------------
interface fc_stream_host_if #(
    parameter int unsigned T = 16
);
    logic                tx_valid;
    logic                tx_ready;
    logic signed [T-1:0] tx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic signed [T-1:0] rx_data;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data
    );
endinterface

// File: rtl/fc_host_regfile.sv
// -----------------------------------------------------------------------------
// fc_host_regfile
// Small register file: one synchronous write port, one combinational read
// port, asynchronous clear of every entry on reset.
//   clk, reset        : clock, async active-high clear
//   wr_en/addr/data   : write port; addresses >= DEPTH are ignored
//   rd_addr / rd_data : combinational read; addresses >= DEPTH read as 0
// -----------------------------------------------------------------------------
module fc_host_regfile
    import fc_host_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned T     = 16,
    localparam int unsigned AW    = index_width(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [T-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic signed [T-1:0] rd_data
);

    logic signed [T-1:0] mem_q [DEPTH];

    // NOTE: this storage is a flop array, not an SRAM macro, so clearing every
    // entry on reset is legal and lets a reset mid-run leave no stale data.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // NOTE: the output gets a default before any condition so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/fc_stream_host.sv
// -----------------------------------------------------------------------------
// fc_stream_host
// Stream host for an fc_* matrix-vector layer. A controller loads an N-element
// vector, pulses start, and the host streams the vector into the layer and
// collects the layer's M results into a readable result buffer.
// Ports:
//   clk, reset                  : clock, async active-high reset
//   start                       : run request pulse (ignored while busy)
//   vec_wr_en/addr/data         : vector buffer write port (IDLE/DONE only)
//   res_rd_addr / res_rd_data   : combinational result buffer read port
//   stream (master modport)     : tx channel to layer input, rx from layer output
//   busy / done / err           : in SEND or RECV / in DONE / timeout abort
// Configuration:
//   FC_HOST_TIMEOUT_EN : when defined, a RECV watchdog aborts to DONE with
//                        err=1 after TIMEOUT cycles without an rx handshake.
//                        When undefined, err is always 0 and RECV waits forever.
// -----------------------------------------------------------------------------
module fc_stream_host
    import fc_host_pkg::*;
#(
    parameter  int unsigned M       = 10,
    parameter  int unsigned N       = 8,
    parameter  int unsigned T       = 16,
    parameter  int unsigned TIMEOUT = 256,
    localparam int unsigned VW      = vec_index_width(N),
    localparam int unsigned RW      = res_index_width(M)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                vec_wr_en,
    input  logic [VW-1:0]       vec_wr_addr,
    input  logic signed [T-1:0] vec_wr_data,
    input  logic [RW-1:0]       res_rd_addr,
    output logic signed [T-1:0] res_rd_data,
    fc_stream_host_if.master    stream,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [VW-1:0] TX_LAST = VW'(N - 1);
    localparam logic [RW-1:0] RX_LAST = RW'(M - 1);

    fc_host_state_t      state_q, state_d;
    logic [VW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [RW-1:0]       rx_cnt_q, rx_cnt_d;
    // rx_cnt stops at M-1, so a separate flag records that all M results
    // arrived (only reachable if the layer answers while still in SEND).
    logic                rx_full_q, rx_full_d;
    logic                err_q, err_d;
    logic                tx_hs, rx_hs, tx_last, rx_last;
    logic                wdog_expire;
    logic signed [T-1:0] vec_rd_data;

    // Handshake outputs decode from registered state only.
    assign stream.tx_valid = (state_q == ST_SEND);
    assign stream.rx_ready = ((state_q == ST_SEND) || (state_q == ST_RECV)) && !rx_full_q;
    assign stream.tx_data  = stream.tx_valid ? vec_rd_data : '0;
    assign busy            = (state_q == ST_SEND) || (state_q == ST_RECV);
    assign done            = (state_q == ST_DONE);
    assign err             = err_q;

    assign tx_hs   = stream.tx_valid && stream.tx_ready;
    assign rx_hs   = stream.rx_valid && stream.rx_ready;
    assign tx_last = tx_hs && (tx_cnt_q == TX_LAST);
    assign rx_last = rx_hs && (rx_cnt_q == RX_LAST);

    fc_host_regfile #(.DEPTH(N), .T(T)) u_vec_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (vec_wr_en && !busy),
        .wr_addr (vec_wr_addr),
        .wr_data (vec_wr_data),
        .rd_addr (tx_cnt_q),
        .rd_data (vec_rd_data)
    );

    fc_host_regfile #(.DEPTH(M), .T(T)) u_res_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_hs),
        .wr_addr (rx_cnt_q),
        .wr_data (stream.rx_data),
        .rd_addr (res_rd_addr),
        .rd_data (res_rd_data)
    );

`ifdef FC_HOST_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wdog_q, wdog_d;

    // Counts consecutive idle RECV cycles; held at 0 outside RECV so it
    // restarts from 0 on every RECV entry.
    always_comb begin
        wdog_d = '0;
        if ((state_q == ST_RECV) && !rx_hs) begin
            wdog_d = wdog_q + WW'(1);
        end
    end

    // Expires on the TIMEOUT-th consecutive idle RECV cycle.
    assign wdog_expire = (state_q == ST_RECV) && !rx_hs && (wdog_q == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign wdog_expire    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        rx_full_d = rx_full_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SEND;
                    tx_cnt_d  = '0;
                    rx_cnt_d  = '0;
                    rx_full_d = 1'b0;
                    err_d     = 1'b0;
                end
            end
            ST_SEND: begin
                if (tx_hs && !tx_last) begin
                    tx_cnt_d = tx_cnt_q + VW'(1);
                end
                if (tx_last) begin
                    state_d = (rx_full_q || rx_last) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (rx_last) begin
                    state_d = ST_DONE;
                end else if (wdog_expire) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // rx handshakes occur only in SEND/RECV (rx_ready is 0 elsewhere).
        if (rx_hs) begin
            if (rx_last) begin
                rx_full_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            rx_full_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_full_q <= rx_full_d;
            err_q     <= err_d;
        end
    end

endmodule
